uart_rx: RTL and testbench

Serial receiver for the UART. It consumes the 16x oversampling strobe `ce_16` from the baud generator and recovers 8N1 frames from the asynchronous `ser_in` line. Received bytes appear on a parallel output with a one-cycle valid strobe. Framing errors are flagged separately. The block sits between the pad input and the receive FIFO/register interface, on the same clock as the baud generator.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 27 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   // Ticks per bit from the baud generator.
   localparam int OVERSAMPLE = 16;

   // Tick index inside the start bit where it is re-checked (bit centre).
   localparam int MID_SAMPLE = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART signal bundle: oversampling strobe, serial line, received word and status.
// Latency: n/a (wiring only).
// Backpressure: none; the receive side never stalls and the consumer must take each strobe.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);

   logic                 ce_16;
   logic                 ser_in;
   logic [DATA_BITS-1:0] rx_data;
   logic                 new_rx_data;
   logic                 frame_err;
   logic                 rx_busy;

   // Environment side: drives the line and tick, consumes the results.
   modport master (
      output ce_16, ser_in,
      input  rx_data, new_rx_data, frame_err, rx_busy
   );

   // Receiver side.
   modport slave (
      input  ce_16, ser_in,
      output rx_data, new_rx_data, frame_err, rx_busy
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input, with a selectable reset value.
// Latency: 2 clocks from d_i to q_o.
// Backpressure: none.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture; the reset value keeps a resting line from looking active.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1-style receiver using the x16 strobe; one centre sample per bit, LSB first.
// Latency: 2-clock sync, then strobes one clock after the stop-bit sampling tick.
// Backpressure: none; each received word is a one-cycle strobe that must be taken.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic      clock,
   input  logic      reset_n,
   uart_rx_if.slave  bus
);

   localparam int                 IDX_W    = $clog2(DATA_BITS + 1);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_BITS - 1);
   localparam logic [3:0]         MID_CNT  = 4'(MID_SAMPLE);
   localparam logic [3:0]         END_CNT  = 4'(OVERSAMPLE - 1);

   logic                 rx_s;
   rx_state_t            state_q, state_d;
   logic [3:0]           tick_q, tick_d;
   logic [IDX_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 nrx_q, nrx_d;
   logic                 ferr_q, ferr_d;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d_i     (bus.ser_in),
      .q_o     (rx_s)
   );

   // State, counters, shift register and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         nrx_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         nrx_q   <= nrx_d;
         ferr_q  <= ferr_d;
      end
   end

   // Frame FSM: moves only on ticks; strobes default low so they self-clear every clock.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      nrx_d   = 1'b0;
      ferr_d  = 1'b0;
      if (bus.ce_16) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  tick_d  = '0;
                  state_d = ST_START;
               end
            end
            ST_START: begin
               if (tick_q == MID_CNT) begin
                  if (rx_s) begin
                     // Start bit gone by its centre: treat as noise.
                     state_d = ST_IDLE;
                  end else begin
                     tick_d  = '0;
                     bit_d   = '0;
                     state_d = ST_DATA;
                  end
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
            ST_DATA: begin
               tick_d = tick_q + 4'd1;
               if (tick_q == END_CNT) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == LAST_IDX) begin
                     state_d = ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               tick_d = tick_q + 4'd1;
               if (tick_q == END_CNT) begin
                  if (rx_s) begin
                     data_d  = shift_q;
                     nrx_d   = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = ST_BREAK;
                  end
               end
            end
            ST_BREAK: begin
               // Hold here while the line stays low so a break reports only once.
               if (rx_s) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rx_data     = data_q;
   assign bus.new_rx_data = nrx_q;
   assign bus.frame_err   = ferr_q;
   assign bus.rx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scoreboarded frames, glitch, break, mid-frame reset, ce tied high.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;

   uart_rx_if #(.DATA_BITS(8)) bus ();

   uart_rx #(.DATA_BITS(8)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   bit ce_always = 1'b0;
   int ce_div    = 0;
   int bit_clks  = 64;
   int cyc       = 0;

   logic [7:0] sb[$];
   logic [7:0] mon_exp;
   int         pulse_cyc[$];

   int   nrx_pulses = 0;
   int   nrx_hi     = 0;
   int   fe_pulses  = 0;
   int   fe_hi      = 0;
   logic prev_nrx   = 1'b0;
   logic prev_fe    = 1'b0;
   logic prev_busy  = 1'b0;
   int   busy_rise  = 0;
   int   busy_fall  = 0;
   int   busy_len   = 0;

   int n0, f0, p0, line_hi;

   // Baud strobe: one clock in four, or every clock when tied high.
   initial begin
      bus.ce_16 = 1'b0;
      forever begin
         @(negedge clock);
         ce_div    = (ce_div + 1) % 4;
         bus.ce_16 = ce_always || (ce_div == 0);
      end
   end

   always @(posedge clock) cyc <= cyc + 1;

   // Output monitor: pops the scoreboard on each received word, tracks strobe widths and busy span.
   always @(negedge clock) begin
      if (bus.new_rx_data === 1'b1) begin
         nrx_hi++;
         if (!prev_nrx) begin
            nrx_pulses++;
            pulse_cyc.push_back(cyc);
            checks++;
            assert (sb.size() > 0)
            else begin
               errors++;
               $error("FAIL unexpected_rx got %h expected no word", bus.rx_data);
            end
            if (sb.size() > 0) begin
               mon_exp = sb.pop_front();
               checks++;
               assert (bus.rx_data === mon_exp)
               else begin
                  errors++;
                  $error("FAIL rx_data got %h expected %h", bus.rx_data, mon_exp);
               end
            end
         end
      end
      if (bus.frame_err === 1'b1) begin
         fe_hi++;
         if (!prev_fe) fe_pulses++;
      end
      if (bus.rx_busy === 1'b1 && !prev_busy) busy_rise = cyc;
      if (bus.rx_busy !== 1'b1 && prev_busy) begin
         busy_fall = cyc;
         busy_len  = cyc - busy_rise;
      end
      prev_nrx  = (bus.new_rx_data === 1'b1);
      prev_fe   = (bus.frame_err === 1'b1);
      prev_busy = (bus.rx_busy === 1'b1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_bit(input logic b);
      bus.ser_in = b;
      wait_clks(bit_clks);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   initial begin
      bus.ser_in = 1'b1;
      #2 reset_n = 1'b0;
      wait_clks(5);
      check("rst_rx_data", bus.rx_data, 8'h00);
      check("rst_new_rx_data", bus.new_rx_data, 1'b0);
      check("rst_frame_err", bus.frame_err, 1'b0);
      check("rst_rx_busy", bus.rx_busy, 1'b0);
      reset_n = 1'b1;
      wait_clks(100);

      // Clean 0xA5: busy spans start detect to stop sample, 152 ticks of 4 clocks.
      n0 = nrx_pulses; f0 = fe_pulses;
      sb.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      wait_clks(bit_clks);
      check("a5_pulses", nrx_pulses - n0, 1);
      check("a5_ferr", fe_pulses - f0, 0);
      check("a5_busy_len", busy_len, 608);
      check("a5_rx_data", bus.rx_data, 8'hA5);

      // Back-to-back 0x00 then 0xFF: strobes exactly 10 bit times apart.
      n0 = nrx_pulses; p0 = pulse_cyc.size();
      sb.push_back(8'h00);
      sb.push_back(8'hFF);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      wait_clks(bit_clks);
      check("b2b_pulses", nrx_pulses - n0, 2);
      if (pulse_cyc.size() >= p0 + 2)
         check("b2b_spacing", pulse_cyc[p0+1] - pulse_cyc[p0], 640);
      else
         check("b2b_spacing_missing", pulse_cyc.size(), p0 + 2);

      // 12-clock low glitch: rejected at the mid-start check after 8 ticks.
      n0 = nrx_pulses; f0 = fe_pulses;
      bus.ser_in = 1'b0;
      wait_clks(12);
      bus.ser_in = 1'b1;
      wait_clks(3 * bit_clks);
      check("glitch_pulses", nrx_pulses - n0, 0);
      check("glitch_ferr", fe_pulses - f0, 0);
      check("glitch_busy_len", busy_len, 32);
      check("glitch_rx_data", bus.rx_data, 8'hFF);
      check("glitch_busy", bus.rx_busy, 1'b0);

      // 0x3C with low stop bit, then a 30-bit break.
      n0 = nrx_pulses; f0 = fe_pulses;
      send_frame(8'h3C, 1'b0);
      wait_clks(30 * bit_clks);
      check("brk_busy_held", bus.rx_busy, 1'b1);
      bus.ser_in = 1'b1;
      line_hi = cyc;
      wait_clks(bit_clks);
      check("brk_ferr", fe_pulses - f0, 1);
      check("brk_pulses", nrx_pulses - n0, 0);
      check("brk_rx_data", bus.rx_data, 8'hFF);
      check("brk_busy", bus.rx_busy, 1'b0);
      check("brk_busy_after_line", busy_fall > line_hi, 1'b1);

      // Reset during data bit 4 of 0x55, then a clean 0x81.
      n0 = nrx_pulses;
      fork
         send_frame(8'h55, 1'b1);
         begin
            wait_clks(5 * bit_clks + bit_clks / 2);
            check("rstmid_busy_before", bus.rx_busy, 1'b1);
            reset_n = 1'b0;
            #1;
            check("rstmid_rx_data", bus.rx_data, 8'h00);
            check("rstmid_new_rx_data", bus.new_rx_data, 1'b0);
            check("rstmid_frame_err", bus.frame_err, 1'b0);
            check("rstmid_rx_busy", bus.rx_busy, 1'b0);
         end
      join
      wait_clks(10);
      reset_n = 1'b1;
      wait_clks(bit_clks);
      sb.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      wait_clks(bit_clks);
      check("post_rst_pulses", nrx_pulses - n0, 1);
      check("post_rst_rx_data", bus.rx_data, 8'h81);

      // ce_16 tied high: 16 clocks per bit.
      ce_always = 1'b1;
      bit_clks  = 16;
      wait_clks(50);
      n0 = nrx_pulses;
      sb.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      wait_clks(2 * bit_clks);
      check("fast_pulses", nrx_pulses - n0, 1);
      check("fast_busy_len", busy_len, 152);
      check("fast_rx_data", bus.rx_data, 8'h5A);

      check("nrx_one_clock", nrx_hi, nrx_pulses);
      check("ferr_one_clock", fe_hi, fe_pulses);
      check("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
